// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives a 1-bit ALU slice LSB first over WIDTH cycles.
// Optional macro SERIAL_ALU_CTRL_SLT_EN enables the set-less-than fix-up for op 0111.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_op_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;

  logic             ai_s, bi_s, sum_s, sc_s, slice_res_s;
  logic             arith_s, ovf_s, set_s, last_s;
  logic [WIDTH-1:0] shifted_s, final_res_s;

  // One ALU slice: inverters, full adder and the Operation mux (less tied to 0).
  always_comb begin
    ai_s  = a_q[0] ^ op_q[3];
    bi_s  = b_q[0] ^ op_q[2];
    sum_s = ai_s ^ bi_s ^ carry_q;
    sc_s  = (ai_s & bi_s) | (ai_s & carry_q) | (bi_s & carry_q);
    case (op_q[1:0])
      2'b00:   slice_res_s = ai_s & bi_s;
      2'b01:   slice_res_s = ai_s | bi_s;
      2'b10:   slice_res_s = sum_s;
      default: slice_res_s = 1'b0;
    endcase
  end

  // Final result and flag selection, valid during the last RUN bit.
  always_comb begin
    last_s    = (cnt_q == CW'(WIDTH - 1));
    shifted_s = {slice_res_s, res_q[WIDTH-1:1]};
    arith_s   = (op_q == 4'b0010) || (op_q == 4'b0110) || (op_q == 4'b0111);
    ovf_s     = carry_q ^ sc_s;
    set_s     = sum_s ^ ovf_s;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: final_res_s = shifted_s;
`ifdef SERIAL_ALU_CTRL_SLT_EN
      4'b0111: final_res_s = {{(WIDTH-1){1'b0}}, set_s};
`else
      4'b0111: final_res_s = '0;
`endif
      default: final_res_s = '0;
    endcase
  end

  // Sequencer next-state: accept, shift one bit per cycle, publish on last bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    res_d    = res_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          op_d    = alu_op_i;
          res_d   = '0;
          carry_d = alu_op_i[2];
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = shifted_s;
        carry_d = sc_s;
        if (last_s) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = final_res_s;
          zero_d   = (final_res_s == '0);
          ovf_d    = arith_s & ovf_s;
          cout_d   = arith_s & sc_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'b0000;
      res_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign cout_o     = cout_q;

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that runs a WIDTH-bit ALU operation through a single 1-bit ALU slice, one bit per clock, LSB first. The slice has a+b inputs, Ainvert, Binvert, a 2-bit Operation select, carry-in and a `less` input. This block owns:
- the operand shift registers;
- the carry flip-flop that chains slice Cout back to Cin;
- result assembly, set-less-than fix-up and status flags.

It sits between the datapath's instruction decode (start/alu_op) and the register write-back (done/result).

## Interface
Parameters
- WIDTH, 8, operand/result width in bits (≥2)

Ports
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- alu_op  in  4  {Ainvert, Binvert, Operation[1:0]}, captured on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  final result, held until next done
- zero  out  1  result == 0, held with result
- overflow  out  1  signed overflow (add/sub only), held
- cout  out  1  carry out of MSB (add/sub only), held

## Operation
- Supported alu_op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
- Any other code is accepted and sequenced normally, but result=0, zero=1, overflow=0, cout=0.
- States:
  - IDLE: accept start.
  - RUN: WIDTH cycles, bit index i = 0..WIDTH-1.
  - DONE: one cycle, pulses done, returns to IDLE.
- Accepted start latches a, b, alu_op, clears the internal result shift register, and sets carry FF = Binvert (SUB/SLT carry-in 1).
- Each RUN cycle applies to the slice:
  - a[i], b[i], Ainvert, Binvert, Operation, Cin = carry FF, less = 0;
  - slice Result shifts into result MSB side;
  - slice Cout loads carry FF.
- At i = WIDTH-1, register:
  - carry-in to MSB (c_msb_in);
  - carry-out (c_msb_out);
  - the MSB sum bit (slice adder output, independent of Operation).
- Flags:
  - overflow = c_msb_in ^ c_msb_out for ADD/SUB/SLT, else 0;
  - cout = c_msb_out for ADD/SUB/SLT, else 0.
- SLT: set = msb_sum ^ overflow; final result = {WIDTH-1 zeros, set}.
- zero is computed on the final (post-SLT) result.
- start in RUN or DONE is ignored, not queued.
- Operand/alu_op input changes after acceptance have no effect.

## Timing
- Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, zero=0, overflow=0, cout=0; carry FF=0.
- Start sampled high in IDLE at edge k: busy=1 from k through k+WIDTH-1 edges (WIDTH cycles).
- done=1 for exactly the cycle after edge k+WIDTH. result/zero/overflow/cout update at that same edge.
- Latency start→done = WIDTH+1 cycles.
- Back-to-back: start may be high during the DONE cycle but is ignored. The earliest next acceptance is the first IDLE cycle, giving WIDTH+2 cycles per operation.
- Outputs result/zero/overflow/cout change only on the done edge or reset. They are stable at all other times.
- Reset asserted mid-RUN or in DONE: the operation is aborted, no done pulse, all outputs cleared. The next start after deassertion behaves normally.

## Configuration
- SERIAL_ALU_CTRL_SLT_EN defined: SLT fix-up logic is present; 0111 behaves as above.
- Not defined: the set fix-up logic is omitted.
  - 0111 returns result=0, zero=1.
  - overflow/cout still reflect the subtraction.
  - All other codes are unchanged.

## Test plan
- WIDTH=8, ADD a=8'h7F b=8'h01:
  - busy for 8 cycles; done 9 cycles after start;
  - result=8'h80, overflow=1, cout=0, zero=0.
- SUB a=8'h05 b=8'h05 → result=8'h00, zero=1, cout=1, overflow=0.
- SLT (macro on):
  - a=8'hFE b=8'h03 → result=8'h01;
  - a=8'h03 b=8'hFE → 8'h00, zero=1;
  - a=8'h80 b=8'h01 → 8'h01 (overflow case);
  - macro off, a=8'hFE b=8'h03 → 8'h00.
- Logic:
  - AND F0/3C → 8'h30;
  - OR F0/0F → 8'hFF;
  - NOR F0/0F → 8'h00 zero=1;
  - overflow=0 and cout=0 for all three.
- Start pulsed again at RUN cycle 3 with different operands → ignored. Exactly one done, carrying the original result.
- rst_n low at RUN bit 3 of an ADD → busy=0 and outputs 0 immediately, no done. The following ADD 8'h10+8'h20 → 8'h30.
